// File: rtl/i2s_apb_pkg.sv
// Shared APB types and register map for the transceiver register bus.
// Used by the command master, the register slave and benches.
package i2s_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic [31:0] REG_CTRL = 32'h0000_0000;
  localparam logic [31:0] REG_TX   = 32'h0000_0004;
  localparam logic [31:0] REG_RX   = 32'h0000_0008;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command in flight, response held until consumed.
// Zero-wait latency 3 cycles accept-to-response; wait-state timeout aborts a hung slave.
module apb_cmd_master
  import i2s_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  apb_state_e       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout_hit;

  assign cmd_ready     = (r_state == IDLE) && !rsp_valid;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // Payload is left as-is on handshake so the last response stays readable.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          penable    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            r_state     <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (w_timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            r_state     <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (r_wait_cnt != {CNT_W{1'b1}}) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed + randomized bench for apb_cmd_master with a transaction-level expectation model.
module tb_apb_cmd_master;
  import i2s_apb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;

  int passed = 0;
  int total  = 0;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete transaction. The slave raises pready after 'waits' low cycles
  // (never, if waits >= TIMEOUT). Expected outcome comes from the protocol rules.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input logic serr, input logic [31:0] srd,
                         input int hold, input logic queue_next);
    logic        exp_to, exp_err, stable;
    logic [31:0] exp_rd;
    int          exp_acc, n_acc;
    exp_to  = (TIMEOUT != 0) && (waits >= TIMEOUT);
    exp_acc = exp_to ? TIMEOUT : waits + 1;
    exp_err = exp_to | serr;
    exp_rd  = (exp_to || wr) ? 32'h0 : srd;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_phase", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, wr, addr, wd});
    step();
    chk("access_entry", {psel, penable, cmd_ready}, 3'b110);

    n_acc = 0; stable = 1'b1;
    while (psel && n_acc < 200) begin
      n_acc++;
      if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b1, wr, addr, wd}) stable = 1'b0;
      pready  = (n_acc == waits + 1);
      pslverr = pready ? serr : 1'($urandom);
      prdata  = pready ? srd : $urandom;
      step();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    chk("access_stable", stable, 1'b1);
    chk("access_cycles", n_acc, exp_acc);
    chk("rsp_first", {rsp_valid, psel, penable, rsp_err, rsp_timeout, rsp_rdata},
        {1'b1, 1'b0, 1'b0, exp_err, exp_to, exp_rd});

    rsp_ready = 1'b0;
    if (queue_next) cmd_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, psel} !==
          {1'b1, exp_err, exp_to, exp_rd, 1'b0, 1'b0}) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_hold", stable, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, cmd_ready, psel, rsp_err, rsp_timeout, rsp_rdata},
        {1'b0, 1'b1, 1'b0, exp_err, exp_to, exp_rd});
  endtask

  initial begin
    int          setup_at[8];
    int          n_setup;
    logic [31:0] regs[3];
    regs[0] = REG_CTRL; regs[1] = REG_TX; regs[2] = REG_RX;

    preset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #12;
    chk("reset_state", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready},
        {3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1});
    step();
    preset = 1'b1;
    step();

    // Zero-wait write, 3-wait read, error write, then a normal write after the error
    do_xfer(1'b1, REG_CTRL, 32'h0000_00A5, 0, 1'b0, $urandom, 0, 1'b0);
    do_xfer(1'b0, REG_RX,   32'h1111_2222, 3, 1'b0, 32'hDEAD_BEEF, 1, 1'b0);
    do_xfer(1'b1, REG_TX,   32'h5A5A_0F0F, 2, 1'b1, $urandom, 0, 1'b0);
    do_xfer(1'b1, REG_TX,   32'h0000_0001, 0, 1'b0, $urandom, 0, 1'b0);

    // Timeout: pready held low; and the completion-wins boundary on the last cycle
    do_xfer(1'b0, REG_RX, 32'h0, 1000, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    do_xfer(1'b0, REG_RX, 32'h0, TIMEOUT - 1, 1'b0, 32'h1234_5678, 0, 1'b0);

    // Second command queued while the first response is held for 5 cycles
    do_xfer(1'b0, REG_CTRL, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 5, 1'b1);
    do_xfer(1'b1, REG_RX,   32'h7777_8888, 0, 1'b0, $urandom, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      do_xfer(1'($urandom), regs[$urandom_range(0, 2)], $urandom, $urandom_range(0, 4),
              1'($urandom), $urandom, $urandom_range(0, 2), 1'b0);
    end

    // Streaming: a new SETUP every 4 cycles with zero waits and rsp_ready high
    rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_RX;
    n_setup = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (psel && !penable && n_setup < 8) begin
        setup_at[n_setup] = c;
        n_setup++;
      end
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) step();
    rsp_ready = 1'b0; pready = 1'b0;
    chk("stream_count", n_setup >= 3, 1'b1);
    chk("stream_period_a", setup_at[1] - setup_at[0], 4);
    chk("stream_period_b", setup_at[2] - setup_at[1], 4);
    chk("stream_drained", {psel, rsp_valid, cmd_ready}, 3'b001);

    // Asynchronous reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_TX;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_reset_access", {psel, penable}, 2'b11);
    #2 preset = 1'b0;
    #1;
    chk("async_reset", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
    step();
    preset = 1'b1;
    step();
    chk("post_reset_idle", {psel, rsp_valid, cmd_ready}, 3'b001);
    do_xfer(1'b0, REG_CTRL, 32'h0, 0, 1'b0, 32'h0000_00C3, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
